// File: rtl/ln_var_stream.sv
// ----------------------------------------------------------------------------
// ln_var_stream
//   Streaming mean / population-variance engine for the LayerNorm datapath.
//   A vector of VEC_LEN signed samples arrives LANES at a time over
//   BEATS = VEC_LEN/LANES beats. One result (mean, variance) is produced per
//   vector, L = log2(LANES)+4 enabled edges after the vector's final beat.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous, active-low reset (overrides i_en)
//   i_en         global clock enable; 0 freezes every register
//   i_valid      beat valid (sampled when i_en=1)
//   i_flush      abort the current partial vector (sampled when i_en=1)
//   i_data_flat  LANES samples, lane k at [DATA_W*k +: DATA_W], two's complement
//   o_valid      one-enabled-cycle result strobe
//   o_mean       sum_x >>> log2(VEC_LEN)
//   o_variance   (sum_sq >>> log2(VEC_LEN)) - (sum_x^2 >>> 2*log2(VEC_LEN))
// ----------------------------------------------------------------------------
module ln_var_stream #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 64,
  parameter int VEC_LEN = 128
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic [LANES*DATA_W-1:0]   i_data_flat,
  output logic                      o_valid,
  output logic [DATA_W-1:0]         o_mean,
  output logic [2*DATA_W-1:0]       o_variance
);

  localparam int LOG_L    = $clog2(LANES);
  localparam int LEN_LOG2 = $clog2(VEC_LEN);
  localparam int BEATS    = VEC_LEN / LANES;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W    = DATA_W + LEN_LOG2;
  localparam int SQ_W     = 2 * DATA_W + LEN_LOG2;
  localparam int NODES    = 2 * LANES - 1;
  localparam int ROOT     = NODES - 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // The adder tree is stored as one flat node array: level 0 (the S0 lane
  // registers) occupies [0, LANES), each following level is packed after the
  // previous one, and the root is the last node.
  function automatic int lvl_off(input int l);
    return 2 * LANES - 2 * (LANES >> l);
  endfunction

  // Datapath registers
  logic signed [SUM_W-1:0]      nx_q [NODES];
  logic signed [SQ_W-1:0]       nq_q [NODES];
  logic signed [SUM_W-1:0]      res_x_q;
  logic signed [SQ_W-1:0]       res_sq_q;
  logic signed [SUM_W-1:0]      m_x_q;
  logic signed [SQ_W-1:0]       m_sq_q;
  logic signed [2*SUM_W-1:0]    m_prod_q;

  // Control / accumulator registers
  logic [CNT_W-1:0]             beat_cnt_q, beat_cnt_d;
  logic [LOG_L:0]               tv_q;     // valid tag per level (0 = S0)
  logic [LOG_L:0]               tf_q;     // final-beat tag per level
  logic signed [SUM_W-1:0]      acc_x_q, acc_x_d;
  logic signed [SQ_W-1:0]       acc_sq_q, acc_sq_d;
  logic                         acc_fin_q, acc_fin_d;
  logic                         res_valid_q;
  logic                         m_valid_q;

  logic [CNT_W-1:0]             cnt_base;
  logic                         last_beat;
  logic                         tree_take;

  // NOTE: every signal written in always_comb gets a default on entry, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    // A flush restarts the count before the same-cycle beat is numbered.
    cnt_base   = i_flush ? '0 : beat_cnt_q;
    last_beat  = (cnt_base == LAST_BEAT);
    beat_cnt_d = cnt_base;
    if (i_valid) beat_cnt_d = last_beat ? '0 : cnt_base + 1'b1;

    // The root beat is discarded if a flush kills the tree in this cycle.
    tree_take = tv_q[LOG_L] & ~i_flush;

    // After a completed vector the accumulators restart from zero while the
    // next vector's first beat is added in the same edge (no bubble).
    acc_x_d   = ((acc_fin_q | i_flush) ? '0 : acc_x_q)  + (tree_take ? nx_q[ROOT] : '0);
    acc_sq_d  = ((acc_fin_q | i_flush) ? '0 : acc_sq_q) + (tree_take ? nq_q[ROOT] : '0);
    acc_fin_d = tree_take & tf_q[LOG_L];
  end

  // NOTE: the wide datapath registers carry no reset; every consumer is
  // qualified by a valid tag, so their contents after reset do not matter.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int k = 0; k < LANES; k++) begin
        nx_q[k] <= SUM_W'($signed(i_data_flat[DATA_W*k +: DATA_W]));
        nq_q[k] <= SQ_W'($signed(i_data_flat[DATA_W*k +: DATA_W]))
                 * SQ_W'($signed(i_data_flat[DATA_W*k +: DATA_W]));
      end
      for (int l = 1; l <= LOG_L; l++) begin
        for (int n = 0; n < (LANES >> l); n++) begin
          nx_q[lvl_off(l) + n] <= nx_q[lvl_off(l-1) + 2*n] + nx_q[lvl_off(l-1) + 2*n + 1];
          nq_q[lvl_off(l) + n] <= nq_q[lvl_off(l-1) + 2*n] + nq_q[lvl_off(l-1) + 2*n + 1];
        end
      end
      if (acc_fin_q) begin
        res_x_q  <= acc_x_q;
        res_sq_q <= acc_sq_q;
      end
      if (res_valid_q) begin
        m_x_q    <= res_x_q;
        m_sq_q   <= res_sq_q;
        m_prod_q <= (2*SUM_W)'(res_x_q) * (2*SUM_W)'(res_x_q);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's value from before the edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      beat_cnt_q  <= '0;
      tv_q        <= '0;
      tf_q        <= '0;
      acc_x_q     <= '0;
      acc_sq_q    <= '0;
      acc_fin_q   <= 1'b0;
      res_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      o_valid     <= 1'b0;
      o_mean      <= '0;
      o_variance  <= '0;
    end else if (i_en) begin
      beat_cnt_q <= beat_cnt_d;
      tv_q[0]    <= i_valid;
      tf_q[0]    <= i_valid & last_beat;
      for (int l = 1; l <= LOG_L; l++) begin
        tv_q[l] <= tv_q[l-1] & ~i_flush;
        tf_q[l] <= tf_q[l-1] & ~i_flush;
      end
      acc_x_q     <= acc_x_d;
      acc_sq_q    <= acc_sq_d;
      acc_fin_q   <= acc_fin_d;
      // A vector already held complete in ACC survives a flush.
      res_valid_q <= acc_fin_q;
      m_valid_q   <= res_valid_q;
      o_valid     <= m_valid_q;
      if (m_valid_q) begin
        o_mean     <= DATA_W'(m_x_q >>> LEN_LOG2);
        // Truncation is safe: the true variance is bounded by 2^(2*DATA_W-2).
        o_variance <= (2*DATA_W)'((2*SUM_W)'(m_sq_q >>> LEN_LOG2)
                                  - (m_prod_q >>> (2*LEN_LOG2)));
      end
    end
  end

endmodule
